// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, multi-cycle start, exception flush and status outputs of pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int CNT_W  = 6
);
    logic [STAGES-1:0]         stallreq_i;
    logic                      mc_start_i;
    logic [$clog2(STAGES)-1:0] mc_stage_i;
    logic [CNT_W-1:0]          mc_cycles_i;
    logic                      excp_valid_i;
    logic [31:0]               excp_pc_i;
    logic [STAGES-1:0]         stall_o;
    logic                      flush_o;
    logic [31:0]               new_pc_o;
    logic                      mc_busy_o;
    logic                      timeout_o;
    logic [31:0]               stall_cnt_o;

    modport master (
        output stallreq_i, mc_start_i, mc_stage_i, mc_cycles_i, excp_valid_i, excp_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, timeout_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_i, mc_start_i, mc_stage_i, mc_cycles_i, excp_valid_i, excp_pc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with multi-cycle sequencer, stall watchdog and
// optional stall performance counter (enabled by PIPE_CTRL_PERF_CNT_EN).
module pipe_ctrl #(
    parameter int STAGES  = 6,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int SW   = $clog2(STAGES);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic              flush_q;
    logic [31:0]       new_pc_q;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic              mc_busy;
    logic [STAGES-1:0] mc_req, req_eff, stall_raw, stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            stage_q <= stage_d;
        end
    end

    // An exception commit overrides any sequencer activity, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stage_d = stage_q;
        if (bus.excp_valid_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (state_q == BUSY) begin
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? IDLE : BUSY;
        end else if (bus.mc_start_i && bus.mc_cycles_i > CNT_W'(1)) begin
            state_d = BUSY;
            rem_d   = bus.mc_cycles_i - CNT_W'(1);
            stage_d = bus.mc_stage_i;
        end
    end

    always_comb begin
        mc_busy = state_q == BUSY;
        mc_req  = mc_busy ? STAGES'(1) << stage_q :
                  (bus.mc_start_i && |bus.mc_cycles_i) ? STAGES'(1) << bus.mc_stage_i : '0;
    end

    // Stage j stalls whenever any stage at or above j requests a stall.
    always_comb begin
        req_eff = bus.stallreq_i | mc_req;
        for (int j = 0; j < STAGES; j++) stall_raw[j] = |(req_eff >> j);
        stall = flush_q ? '0 : stall_raw;
    end

    always_comb begin
        wd_d      = !stall[0] ? '0 : (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        timeout_d = !flush_q && (timeout_q || wd_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            flush_q   <= bus.excp_valid_i;
            new_pc_q  <= bus.excp_valid_i ? bus.excp_pc_i : new_pc_q;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else if (stall[0] && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`else
    assign bus.stall_cnt_o = 32'h0;
`endif

    assign bus.stall_o   = stall;
    assign bus.flush_o   = flush_q;
    assign bus.new_pc_o  = new_pc_q;
    assign bus.mc_busy_o = mc_busy;
    assign bus.timeout_o = timeout_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline stall/flush controller; successor to the core's combinational CTRL unit.
- Merges per-stage stall requests with an internal multi-cycle stall sequencer (div/mult, multi-cycle memory) and an exception flush path.
- Adds a stall watchdog and a stall performance counter.
- Drives the stall bus consumed by IF/ID/EX/MEM/WB pipeline registers; bit 0 = PC stage.

Parameters:
STAGES, 6, width of stall bus / number of stages (bit k = stage k, 0 = PC)
CNT_W, 6, width of multi-cycle length field
TIMEOUT, 1024, consecutive stall[0] cycles before timeout asserts (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
stallreq  input  STAGES  stall request; bit k from stage k
mc_start  input  1  start a multi-cycle stall (single-cycle pulse)
mc_stage  input  $clog2(STAGES)  stage index held by the multi-cycle stall
mc_cycles  input  CNT_W  total stall length in cycles
excp_valid  input  1  exception/eret commit; flush request
excp_pc  input  32  redirect PC for flush
stall  output  STAGES  stall vector to pipeline registers
flush  output  1  registered one-cycle flush pulse
new_pc  output  32  redirect target, valid while flush=1
mc_busy  output  1  sequencer in BUSY state
timeout  output  1  sticky watchdog flag
stall_cnt  output  32  cycles with stall[0]=1

Behaviour:
- Reset (rst=0, async): stall=0, flush=0, new_pc=0, mc_busy=0, timeout=0, stall_cnt=0; FSM=IDLE; rem=0; watchdog count=0.
- Effective request: req_eff = stallreq | mc_req. mc_req = onehot(mc_stage_q) in BUSY; onehot(mc_stage) in IDLE when mc_start=1 and mc_cycles!=0; else 0.
- stall (combinational): k = highest set bit of req_eff; stall[j]=1 for j<=k, 0 for j>k; req_eff=0 -> stall=0. The stage boundary where stall[k]=1 and stall[k+1]=0 takes a bubble (handled in the pipeline registers).
- Flush override: while flush=1, stall forced to 0.
- Sequencer FSM states IDLE, BUSY:
  - IDLE, mc_start=1, mc_cycles=0: ignored.
  - IDLE, mc_start=1, mc_cycles=1: stall in the start cycle only; FSM stays IDLE.
  - IDLE, mc_start=1, mc_cycles=N>=2: stall in the start cycle; latch mc_stage_q; rem=N-1; next state BUSY.
  - BUSY: stall asserted; rem decrements each cycle; at rem==1, next state IDLE.
  - Total stall length = N cycles exactly.
  - mc_start while BUSY: ignored.
- mc_busy = (state==BUSY).
- Flush: excp_valid=1 at edge t -> flush=1 and new_pc=excp_pc in cycle t+1 for one cycle.
  - excp_valid at the same edge forces FSM to IDLE and clears rem; a same-cycle mc_start is discarded.
  - Back-to-back excp_valid gives back-to-back flush pulses; new_pc follows the latest excp_pc.
  - new_pc holds its last value when flush=0.
- Watchdog: consecutive counter increments while stall[0]=1 and clears when stall[0]=0.
  - When the counter reaches TIMEOUT, timeout=1 (registered; rises after the TIMEOUT-th consecutive stall cycle).
  - timeout is sticky; cleared only by reset or flush=1.
  - The counter saturates at TIMEOUT.
- stall_cnt: +1 each cycle stall[0]=1; saturates at 32'hFFFFFFFF; never wraps.

Optional Feature:
PIPE_CTRL_PERF_CNT_EN:
- Defined: stall_cnt counter implemented as above.
- Undefined: no counter flops; stall_cnt tied to 32'h0.
- All other behaviour identical in both builds.

Test Plan:
- STAGES=6, stallreq=6'b000100 for 2 cycles then 0 -> stall=6'b000111 both cycles (same cycle as request), then 6'b000000; stallreq=6'b010010 -> stall=6'b011111.
- mc_start=1, mc_stage=3, mc_cycles=3 -> stall=6'b001111 for exactly 3 cycles starting with the start cycle; mc_busy=1 in cycles 2-3 only; second mc_start in cycle 2 ignored; mc_cycles=0 start -> stall stays 0.
- BUSY with rem=5, excp_valid=1, excp_pc=32'hBFC00380 -> next cycle flush=1, new_pc=32'hBFC00380, stall=0, mc_busy=0; following cycle flush=0.
- TIMEOUT=16, stallreq[2] held 16 cycles -> timeout=1 after the 16th cycle; stays 1 after release; excp_valid pulse -> flush clears timeout; 15-cycle stall, 1 free cycle, 15-cycle stall -> timeout never rises.
- With PIPE_CTRL_PERF_CNT_EN: 7 stalled cycles -> stall_cnt=7. Without it: stall_cnt=0 throughout.
- Assert rst=0 mid-BUSY, asynchronously between edges -> all outputs 0 immediately; after release, stallreq=0 -> stall=0 and FSM IDLE.
